// File: rtl/fb_pkg.sv
// Framebuffer package: geometry constants and the arbiter state type
// shared by the framebuffer arbiter and its sub-modules.
package fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_WORDS  = FB_W * FB_H;
  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 8;

  typedef enum logic {
    READ_PRI    = 1'b0,
    WRITE_FORCE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fb_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   inc_i         count up by one, holding at MAX
//   clr_i         clear to zero (wins over inc_i)
//   cnt_o         current count
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port synchronous RAM between
// the VGA scanout reader (priority) and the pixel-drawing writer. After
// STARVE_MAX consecutive denied write cycles one write slot is forced.
//
// state       | meaning
// ------------|-----------------------------------------------------
// READ_PRI    | scanout reads win; writes go only when no read
// WRITE_FORCE | a pending write wins over any read, for one cycle
//
// Ports:
//   CLOCK_50, reset              clock, asynchronous active-high reset
//   rd_req/rd_addr/rd_gnt        scanout request, address, grant (comb)
//   rd_valid/rd_data             read return, one cycle after rd_gnt
//   wr_valid/wr_addr/wr_data     writer request, held until wr_ready
//   wr_ready                     write accepted this cycle (comb)
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata          RAM port
//   rd_deferred                  saturating count of denied read cycles
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  rd_deferred
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  arb_state_t          state_q, state_d;
  logic                rd_valid_q;
  logic [STARVE_W-1:0] starve_cnt;
  logic                force_wr;
  logic                starve_inc;
  logic                starve_clr;
  logic                starve_hit;
  logic                defer_inc;

  // Grants are gated by reset so the RAM sees no access while held in reset.
  always_comb begin
    force_wr  = (state_q == WRITE_FORCE) && wr_valid;
    rd_gnt    = !reset && rd_req && !force_wr;
    wr_ready  = !reset && wr_valid && (!rd_req || force_wr);
    mem_en    = rd_gnt || wr_ready;
    mem_we    = wr_ready;
    mem_addr  = wr_ready ? wr_addr : rd_addr;
    mem_wdata = wr_data;
  end

  // The counter is cleared whenever it does not increment, so its next
  // value reaches STARVE_MAX exactly when it increments from STARVE_MAX-1
  // or holds at STARVE_MAX.
  always_comb begin
    starve_inc = wr_valid && !wr_ready;
    starve_clr = !starve_inc;
    starve_hit = starve_inc && ((32'(starve_cnt) + 32'd1) >= 32'(STARVE_MAX));
    defer_inc  = rd_req && !rd_gnt;
    state_d    = (state_q == READ_PRI && starve_hit) ? WRITE_FORCE : READ_PRI;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= READ_PRI;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_gnt;
    end
  end

  sat_counter #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_W'(STARVE_MAX))
  ) u_starve_cnt (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .cnt_o (starve_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   ({CNT_W{1'b1}})
  ) u_defer_cnt (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .inc_i (defer_inc),
    .clr_i (1'b0),
    .cnt_o (rd_deferred)
  );

  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_rdata;

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: the VGA scanout reader and the pixel-drawing writer.
- Scanout reads have priority because they carry a display deadline.
- A starvation counter forces a write slot, so drawing always makes progress.
- Sits between the VGA pipeline, the draw engine and the on-chip framebuffer RAM in the DE1-SoC top.

Parameters:
- ADDR_W, 17, framebuffer word address width (320x240 = 76800 words).
- DATA_W, 8, pixel width (RGB332).
- STARVE_MAX, 8, consecutive denied write cycles before one write is forced; legal range 1..255.
- CNT_W, 16, width of the deferred-read statistics counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- rd_req  in  1  scanout requests a read this cycle.
- rd_addr  in  ADDR_W  scanout read address.
- rd_gnt  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  rd_data valid (registered).
- rd_data  out  DATA_W  read data; equals mem_rdata.
- wr_valid  in  1  writer has a pixel to write.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle (combinational).
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, one cycle after the address.
- rd_deferred  out  CNT_W  saturating count of cycles with rd_req high and rd_gnt low.

Behaviour:
- Reset (asynchronous, active-high):
  - rd_valid=0, starve_cnt=0, rd_deferred=0, state=READ_PRI.
  - While reset is high: rd_gnt=0, wr_ready=0, mem_en=0, mem_we=0; mem_addr and mem_wdata are don't-care.
- One RAM access per cycle at most. Arbitration is combinational from the current state and requests.
- State READ_PRI:
  - rd_req=1 -> rd_gnt=1, mem_en=1, mem_we=0, mem_addr=rd_addr; wr_ready=0.
  - rd_req=0 and wr_valid=1 -> wr_ready=1, mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Neither request -> mem_en=0.
- State WRITE_FORCE:
  - wr_valid=1 -> write granted exactly as above; rd_gnt=0 even if rd_req=1.
  - wr_valid=0 -> behaves as READ_PRI.
- starve_cnt, width clog2(STARVE_MAX+1):
  - wr_valid and not wr_ready -> increment, saturating at STARVE_MAX.
  - wr_ready or not wr_valid -> clear to 0.
- State transitions:
  - Next state is WRITE_FORCE when the next value of starve_cnt equals STARVE_MAX.
  - Next state is READ_PRI after any cycle spent in WRITE_FORCE.
  - Result: at most one forced write per STARVE_MAX+1 cycles under continuous read load.
- Read latency:
  - rd_valid is rd_gnt delayed one cycle; rd_data=mem_rdata in that cycle.
  - Fixed latency of 1; no back-pressure on read data.
- Writer handshake: a transfer occurs on wr_valid and wr_ready. The writer holds wr_addr and wr_data stable until accepted.
- Same-address collisions:
  - Read and write in different cycles are ordered by grant order.
  - A read granted the same cycle a write is pending returns the old data.
  - A forced write followed by a read returns the new data.
- rd_deferred increments on rd_req and not rd_gnt, saturating at 2^CNT_W-1. It is cleared only by reset.
- Reset asserted mid-read: the in-flight rd_valid is dropped and no stale valid appears after deassertion.
- STARVE_MAX=1: every other cycle under full contention is a forced write.

Decomposition:
- Package fb_pkg:
  - FB_W=320, FB_H=240, FB_ADDR_W=17, FB_DATA_W=8.
  - Enum arb_state_t {READ_PRI, WRITE_FORCE}.
- Sub-module sat_counter (parameter WIDTH, MAX; inputs inc, clr), instantiated for starve_cnt and rd_deferred.

Test Plan:
1. Reset then idle: reset=1 for 3 cycles, then no requests -> mem_en=0, rd_valid=0, rd_deferred=0 throughout.
2. Read only: rd_req with addresses 0..9 back-to-back, RAM preloaded with addr&0xFF -> rd_gnt=1 every cycle; rd_valid one cycle later with rd_data=0..9 in order.
3. Write only: wr_valid to addr 100 with data 0xA5, no reads -> wr_ready in the same cycle, mem_we=1, mem_addr=100; a later read of 100 returns 0xA5.
4. Starvation, STARVE_MAX=4: continuous rd_req plus wr_valid held -> writes accepted on cycles 5, 10, 15 (one in five); rd_deferred increments by 1 per forced cycle.
5. Collision: write 0x3C to addr 7 pending, read of addr 7 granted first -> old value returned; after the forced write, a new read of 7 returns 0x3C.
6. Reset mid-operation: reset asserted the cycle after a read grant -> rd_valid stays 0; starve_cnt and rd_deferred return to 0; state is READ_PRI after release.
